// File: rtl/saltos.sv
// -----------------------------------------------------------------------------
// saltos - branch/jump decision unit of the processor control path.
//
// Combines the decoder's 4-bit jump-condition code with the ALU status flags.
// It produces the registered program-counter source select one clock later.
//
// Ports
//   i_Clk            in   1  system clock, rising-edge active
//   i_Rst            in   1  synchronous, active-high reset (select -> PC+1)
//   i_Control_Salto  in   4  jump-condition code from the instruction decoder
//   i_BanEstado      in   3  status flags: [0]=Z zero, [1]=C carry, [2]=N negative
//   o_Salto_PC       out  2  PC source select (registered):
//                              00 PC+1, 01 jump target, 10 return address,
//                              11 hold PC
//
// The decision is purely a function of the current code and flags. HALT is
// not remembered here: the decoder must keep issuing HALT to stay halted.
// -----------------------------------------------------------------------------
module saltos (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Control_Salto,
    input  logic [2:0] i_BanEstado,
    output logic [1:0] o_Salto_PC
);

    // PC source select encodings
    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_RETURN = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b11;

    // Jump-condition codes
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0100;
    localparam logic [3:0] OP_JNC  = 4'b0101;
    localparam logic [3:0] OP_JN   = 4'b0110;
    localparam logic [3:0] OP_JNN  = 4'b0111;
    localparam logic [3:0] OP_JA   = 4'b1000;
    localparam logic [3:0] OP_JBE  = 4'b1001;
    localparam logic [3:0] OP_JG   = 4'b1010;
    localparam logic [3:0] OP_JLE  = 4'b1011;
    localparam logic [3:0] OP_CALL = 4'b1100;
    localparam logic [3:0] OP_RET  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;

    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       cond_taken;
    logic [1:0] sel_next;
    logic [1:0] sel_reg;

    assign flag_z = i_BanEstado[0];
    assign flag_c = i_BanEstado[1];
    assign flag_n = i_BanEstado[2];

    // Condition evaluation for the flag-dependent codes. Flags a code does
    // not mention never reach its term.
    always_comb begin
        cond_taken = 1'b0;
        case (i_Control_Salto)
            OP_JZ:   cond_taken = flag_z;
            OP_JNZ:  cond_taken = ~flag_z;
            OP_JC:   cond_taken = flag_c;
            OP_JNC:  cond_taken = ~flag_c;
            OP_JN:   cond_taken = flag_n;
            OP_JNN:  cond_taken = ~flag_n;
            OP_JA:   cond_taken = ~flag_c & ~flag_z;   // unsigned above
            OP_JBE:  cond_taken = flag_c | flag_z;     // unsigned below-or-equal
            OP_JG:   cond_taken = ~flag_n & ~flag_z;   // signed greater
            OP_JLE:  cond_taken = flag_n | flag_z;     // signed less-or-equal
            default: cond_taken = 1'b0;
        endcase
    end

    // Select decode. Every code has an explicit arm or falls into the
    // default, so all 128 input combinations give a defined value.
    always_comb begin
        sel_next = SEL_SEQ;
        case (i_Control_Salto)
            OP_NOP:  sel_next = SEL_SEQ;
            OP_JMP,
            OP_CALL: sel_next = SEL_TARGET;
            OP_RET:  sel_next = SEL_RETURN;
            OP_HALT: sel_next = SEL_HOLD;
            OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_JN, OP_JNN,
            OP_JA, OP_JBE, OP_JG, OP_JLE:
                     sel_next = cond_taken ? SEL_TARGET : SEL_SEQ;
            default: sel_next = SEL_SEQ;   // reserved code 1111
        endcase
    end

    // Single output register. This gives exactly one cycle of latency and
    // no combinational path from the inputs to o_Salto_PC.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sel_reg <= SEL_SEQ;
        end else begin
            sel_reg <= sel_next;
        end
    end

    assign o_Salto_PC = sel_reg;

endmodule

// File: tb/tb_saltos.sv
module tb_saltos;

    logic       clk;
    logic       rst;
    logic [3:0] ctrl;
    logic [2:0] flags;
    logic [1:0] sel;

    int n_checks = 0;
    int n_fail   = 0;

    saltos dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Control_Salto (ctrl),
        .i_BanEstado     (flags),
        .o_Salto_PC      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decision. The flags are named first, and each mnemonic is
    // mapped to its behaviour: taken or not, then which PC source applies.
    function automatic logic [1:0] model_sel(input logic [3:0] c, input logic [2:0] f);
        bit z, cy, n, taken;
        z  = f[0];
        cy = f[1];
        n  = f[2];
        taken = 1'b0;
        if (c == 4'd13) return 2'b10;                 // RET
        if (c == 4'd14) return 2'b11;                 // HALT
        case (c)
            4'd1, 4'd12: taken = 1'b1;                // JMP, CALL
            4'd2:  taken = z;
            4'd3:  taken = !z;
            4'd4:  taken = cy;
            4'd5:  taken = !cy;
            4'd6:  taken = n;
            4'd7:  taken = !n;
            4'd8:  taken = !(cy || z);
            4'd9:  taken = cy || z;
            4'd10: taken = !(n || z);
            4'd11: taken = n || z;
            default: taken = 1'b0;                    // NOP, reserved
        endcase
        return taken ? 2'b01 : 2'b00;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (ctrl=%b flags=%b rst=%b) at %0t",
                     name, act, exp, ctrl, flags, rst, $time);
        end
    endtask

    // Model tracking: what the output must be after each edge.
    logic [1:0] exp_sel;
    bit         exp_valid = 1'b0;

    always @(posedge clk) begin
        exp_sel   <= rst ? 2'b00 : model_sel(ctrl, flags);
        exp_valid <= 1'b1;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) check("model", sel, exp_sel);
    end

    // Drive one transaction, clock it through, then check the hand-computed value.
    task automatic apply(input string name, input logic r, input logic [3:0] c,
                         input logic [2:0] f, input logic [1:0] exp);
        @(negedge clk);
        rst   = r;
        ctrl  = c;
        flags = f;
        @(posedge clk);
        #1;
        $display("tx %-10s rst=%b ctrl=%b flags=%b -> sel=%b (want %b)", name, r, c, f, sel, exp);
        check(name, sel, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst   = 1'b1;
        ctrl  = 4'b0001;
        flags = 3'b000;

        // Reset with a jump code present, then release
        apply("rst_jmp",  1'b1, 4'b0001, 3'b000, 2'b00);
        apply("rst_jmp2", 1'b1, 4'b0001, 3'b000, 2'b00);
        apply("rel_jmp",  1'b0, 4'b0001, 3'b000, 2'b01);

        // Unconditional and special codes
        apply("nop",      1'b0, 4'b0000, 3'b000, 2'b00);
        apply("jmp",      1'b0, 4'b0001, 3'b000, 2'b01);
        apply("call",     1'b0, 4'b1100, 3'b000, 2'b01);
        apply("ret",      1'b0, 4'b1101, 3'b000, 2'b10);
        apply("halt",     1'b0, 4'b1110, 3'b000, 2'b11);
        apply("rsvd",     1'b0, 4'b1111, 3'b000, 2'b00);

        // Single-flag conditions
        apply("jz_010",   1'b0, 4'b0010, 3'b010, 2'b00);
        apply("jnz_011",  1'b0, 4'b0011, 3'b011, 2'b00);
        apply("jc_100",   1'b0, 4'b0100, 3'b100, 2'b00);
        apply("jnc_101",  1'b0, 4'b0101, 3'b101, 2'b01);
        apply("jn_110",   1'b0, 4'b0110, 3'b110, 2'b01);
        apply("jnn_111",  1'b0, 4'b0111, 3'b111, 2'b00);

        // Compound conditions
        apply("ja_000",   1'b0, 4'b1000, 3'b000, 2'b01);
        apply("jbe_001",  1'b0, 4'b1001, 3'b001, 2'b01);
        apply("jg_010",   1'b0, 4'b1010, 3'b010, 2'b01);
        apply("jle_001",  1'b0, 4'b1011, 3'b001, 2'b01);
        apply("ja_010",   1'b0, 4'b1000, 3'b010, 2'b00);
        apply("jg_100",   1'b0, 4'b1010, 3'b100, 2'b00);

        // HALT is not sticky
        apply("halt2",    1'b0, 4'b1110, 3'b111, 2'b11);
        apply("after_h",  1'b0, 4'b0000, 3'b111, 2'b00);

        // Mid-stream reset while a jump is applied, then the first decode after release
        apply("rst_mid",  1'b1, 4'b0001, 3'b000, 2'b00);
        apply("post_ret", 1'b0, 4'b1101, 3'b000, 2'b10);

        // Latency: a mid-cycle input change must not reach the output before the edge
        apply("lat_nop",  1'b0, 4'b0000, 3'b000, 2'b00);
        #2;
        ctrl = 4'b0001;
        #1;
        check("lat_hold", sel, 2'b00);
        @(posedge clk);
        #1;
        $display("tx %-10s rst=0 ctrl=0001 flags=000 -> sel=%b (want 01)", "lat_edge", sel);
        check("lat_edge", sel, 2'b01);

        // Exhaustive sweep, back to back, checked against the model
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 8; f++) begin
                apply($sformatf("sw_%0d_%0d", c, f), 1'b0, 4'(c), 3'(f),
                      model_sel(4'(c), 3'(f)));
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
